// File: rtl/vector_l1_classifier_pkg.sv
// Shared types, default widths and sizing helper for the L1 vector classifier.
package vector_l1_classifier_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DECIDE = 2'd2
   } state_e;

   localparam int unsigned DEF_DATA_WIDTH = 4;
   localparam int unsigned DEF_ADDR_BITS  = 6;
   localparam int unsigned DEF_VEC_LEN    = 64;
   localparam int unsigned DEF_ACC_WIDTH  = 10;

   // Smallest accumulator that can hold VEC_LEN maximal element differences.
   function automatic int unsigned min_acc_width(input int unsigned vec_len,
                                                 input int unsigned data_width);
      return $clog2(vec_len * ((2 ** data_width) - 1) + 1);
   endfunction

endpackage

// File: rtl/vector_l1_classifier_acc.sv
// One absolute-difference accumulator with synchronous clear and enable.
module l1_dist_acc
   import vector_l1_classifier_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [ACC_WIDTH-1:0]  acc_o
);

   logic [DATA_WIDTH-1:0] diff_c;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;

   assign diff_c = (a_i > b_i) ? (a_i - b_i) : (b_i - a_i);

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + ACC_WIDTH'(diff_c);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/vector_l1_classifier.sv
// Sweeps the shared memory address, accumulates L1 distances to the healthy and
// infected references, and issues a one-cycle healthy/infected decision.
module vector_l1_classifier
   import vector_l1_classifier_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
   parameter int unsigned VEC_LEN    = DEF_VEC_LEN,
   parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_BITS-1:0]  vec_addr,
   input  logic [DATA_WIDTH-1:0] feat_data,
   input  logic [DATA_WIDTH-1:0] healthy_data,
   input  logic [DATA_WIDTH-1:0] infected_data,
   output logic                  busy,
   output logic                  done,
   output logic                  is_infected,
   output logic                  tie,
   output logic [ACC_WIDTH-1:0]  dist_healthy,
   output logic [ACC_WIDTH-1:0]  dist_infected
);

   if (ACC_WIDTH < min_acc_width(VEC_LEN, DATA_WIDTH)) begin : g_acc_width_chk
      $error("ACC_WIDTH too small for VEC_LEN and DATA_WIDTH");
   end
   if (VEC_LEN > (2 ** ADDR_BITS)) begin : g_vec_len_chk
      $error("VEC_LEN exceeds the address range");
   end

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(VEC_LEN - 1);

   state_e                 state_q, state_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   inf_q, inf_d;
   logic                   tie_q, tie_d;
   logic [ACC_WIDTH-1:0]   dist_h_q, dist_h_d;
   logic [ACC_WIDTH-1:0]   dist_p_q, dist_p_d;
   logic                   acc_clr_c;
   logic                   acc_en_c;
   logic [ACC_WIDTH-1:0]   acc_h_c;
   logic [ACC_WIDTH-1:0]   acc_p_c;

   l1_dist_acc #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_healthy (
      .clk   (clk),
      .rst   (rst),
      .clr_i (acc_clr_c),
      .en_i  (acc_en_c),
      .a_i   (feat_data),
      .b_i   (healthy_data),
      .acc_o (acc_h_c)
   );

   l1_dist_acc #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_infected (
      .clk   (clk),
      .rst   (rst),
      .clr_i (acc_clr_c),
      .en_i  (acc_en_c),
      .a_i   (feat_data),
      .b_i   (infected_data),
      .acc_o (acc_p_c)
   );

   // Next-state, address sweep and decision; done defaults low so it strobes once.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      inf_d     = inf_q;
      tie_d     = tie_q;
      dist_h_d  = dist_h_q;
      dist_p_d  = dist_p_q;
      acc_clr_c = 1'b0;
      acc_en_c  = 1'b0;
      case (state_q)
         IDLE: begin
            addr_d = '0;
            if (start) begin
               acc_clr_c = 1'b1;
               busy_d    = 1'b1;
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            acc_en_c = 1'b1;
            if (addr_q == LAST_ADDR) begin
               state_d = DECIDE;
            end else begin
               addr_d = addr_q + ADDR_BITS'(1);
            end
         end
         DECIDE: begin
            dist_h_d = acc_h_c;
            dist_p_d = acc_p_c;
            inf_d    = (acc_p_c < acc_h_c);
            tie_d    = (acc_p_c == acc_h_c);
            done_d   = 1'b1;
            busy_d   = 1'b0;
            addr_d   = '0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         inf_q    <= 1'b0;
         tie_q    <= 1'b0;
         dist_h_q <= '0;
         dist_p_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         inf_q    <= inf_d;
         tie_q    <= tie_d;
         dist_h_q <= dist_h_d;
         dist_p_q <= dist_p_d;
      end
   end

   assign vec_addr      = addr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign is_infected   = inf_q;
   assign tie           = tie_q;
   assign dist_healthy  = dist_h_q;
   assign dist_infected = dist_p_q;

endmodule

// File: tb/tb_vector_l1_classifier.sv
// Directed self-checking bench for vector_l1_classifier with behavioural memories.
module tb_vector_l1_classifier;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] vec_addr;
   logic [3:0] feat_data;
   logic [3:0] healthy_data;
   logic [3:0] infected_data;
   logic       busy;
   logic       done;
   logic       is_infected;
   logic       tie;
   logic [9:0] dist_healthy;
   logic [9:0] dist_infected;

   logic [3:0] feat_mem [64];
   logic [3:0] hlth_mem [64];
   logic [3:0] infd_mem [64];

   int checks   = 0;
   int failures = 0;

   assign feat_data     = feat_mem[vec_addr];
   assign healthy_data  = hlth_mem[vec_addr];
   assign infected_data = infd_mem[vec_addr];

   vector_l1_classifier dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .vec_addr      (vec_addr),
      .feat_data     (feat_data),
      .healthy_data  (healthy_data),
      .infected_data (infected_data),
      .busy          (busy),
      .done          (done),
      .is_infected   (is_infected),
      .tie           (tie),
      .dist_healthy  (dist_healthy),
      .dist_infected (dist_infected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load(input int f, input int h, input int p);
      for (int i = 0; i < 64; i++) begin
         feat_mem[i] = 4'(f);
         hlth_mem[i] = 4'(h);
         infd_mem[i] = 4'(p);
      end
   endtask

   // Start one run, wait (bounded) for done, check latency and results.
   task automatic run(input string tag, input int eh, input int ep, input int einf, input int etie);
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 65);
      chk({tag, "_dist_h"}, dist_healthy, eh);
      chk({tag, "_dist_p"}, dist_infected, ep);
      chk({tag, "_inf"}, is_infected, einf);
      chk({tag, "_tie"}, tie, etie);
      chk({tag, "_busy_at_done"}, busy, 0);
      tick();
      chk({tag, "_done_clear"}, done, 0);
      chk({tag, "_held_h"}, dist_healthy, eh);
   endtask

   initial begin
      int n;
      int dones;
      rst   = 1'b1;
      start = 1'b0;
      load(0, 0, 15);
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", vec_addr, 0);
      chk("rst_dist_h", dist_healthy, 0);
      chk("rst_dist_p", dist_infected, 0);
      #3 rst = 1'b0;
      tick();

      // Test 1: address sweep and result timing in detail.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_busy_e0", busy, 1);
      chk("t1_addr_e0", vec_addr, 0);
      for (int k = 1; k <= 63; k++) begin
         tick();
         chk("t1_addr_step", vec_addr, k);
         chk("t1_no_early_done", done, 0);
      end
      tick();
      chk("t1_addr_hold_decide", vec_addr, 63);
      chk("t1_done_e64", done, 0);
      tick();
      chk("t1_done_e65", done, 1);
      chk("t1_dist_h", dist_healthy, 0);
      chk("t1_dist_p", dist_infected, 960);
      chk("t1_inf", is_infected, 0);
      chk("t1_tie", tie, 0);
      chk("t1_addr_after", vec_addr, 0);
      tick();
      chk("t1_done_e66", done, 0);

      // Test 2: infected wins.
      load(15, 0, 15);
      run("t2", 960, 0, 1, 0);

      // Test 3: tie resolves healthy.
      load(4, 3, 5);
      run("t3", 64, 64, 0, 1);

      // Test 4: start while busy is ignored.
      load(0, 0, 15);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 10;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("t4_latency", n, 65);
      chk("t4_dist_p", dist_infected, 960);
      chk("t4_inf", is_infected, 0);
      dones = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (done) dones++;
      end
      chk("t4_no_second_done", dones, 0);
      chk("t4_idle_busy", busy, 0);

      // Test 5: asynchronous reset mid-sweep.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 30; k++) tick();
      chk("t5_busy_before_rst", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_addr", vec_addr, 0);
      chk("t5_rst_done", done, 0);
      chk("t5_rst_dist_p", dist_infected, 0);
      chk("t5_rst_tie", tie, 0);
      tick();
      #3 rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (done) dones++;
      end
      chk("t5_no_done_after_rst", dones, 0);
      for (int i = 0; i < 64; i++) begin
         feat_mem[i] = 4'(i % 16);
         hlth_mem[i] = 4'd0;
         infd_mem[i] = 4'd15;
      end
      run("t5_mixed", 480, 480, 0, 1);

      // Test 6: start held high restarts right after each result.
      load(15, 0, 15);
      start = 1'b1;
      tick();
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("t6_first_latency", n, 65);
      chk("t6_busy_low_at_done", busy, 0);
      chk("t6_first_dist_h", dist_healthy, 960);
      tick();
      chk("t6_restart_busy", busy, 1);
      chk("t6_restart_done_clear", done, 0);
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("t6_second_latency", n, 65);
      chk("t6_second_inf", is_infected, 1);
      start = 1'b0;
      tick();
      chk("t6_done_clear", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vector_l1_classifier.md
Name: vector_l1_classifier

Overview:
- Final decision stage of the CNN datapath. Sits directly downstream of the healthy and infected reference-vector BRAMs and the CNN feature-vector memory.
- Sweeps one shared address over all three async-read memories and accumulates the L1 (Manhattan) distance of the feature vector to each reference.
- Issues a one-cycle classification result: healthy or infected.

Parameters:
- DATA_WIDTH, 4, width of each unsigned vector element; matches the reference BRAM width.
- ADDR_BITS, 6, width of the address driven to the memories.
- VEC_LEN, 64, number of elements compared; must be <= 2**ADDR_BITS.
- ACC_WIDTH, 10, accumulator width; must be >= clog2(VEC_LEN*(2**DATA_WIDTH-1)+1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request classification; sampled only in IDLE.
- vec_addr  output  ADDR_BITS  shared read address to the feature, healthy and infected memories.
- feat_data  input  DATA_WIDTH  feature element at vec_addr (async read, same cycle).
- healthy_data  input  DATA_WIDTH  healthy reference element at vec_addr.
- infected_data  input  DATA_WIDTH  infected reference element at vec_addr.
- busy  output  1  high from start acceptance until result issue.
- done  output  1  one-cycle result strobe.
- is_infected  output  1  1 = infected, 0 = healthy; held until next done.
- tie  output  1  distances equal; held until next done.
- dist_healthy  output  ACC_WIDTH  final L1 distance to the healthy reference; held.
- dist_infected  output  ACC_WIDTH  final L1 distance to the infected reference; held.

Behaviour:
- Reset (async, rst=1): state=IDLE; vec_addr, busy, done, is_infected, tie, dist_* and accumulators all 0. Reset mid-sweep aborts the sweep with no done.
- States are IDLE, ACCUM and DECIDE.
- IDLE:
  - vec_addr held at 0.
  - start=1 at edge E0: clear acc_h and acc_p, vec_addr<=0, busy<=1, go to ACCUM.
- ACCUM (edges E1..E_VEC_LEN):
  - Each edge: acc_h += |feat_data-healthy_data| and acc_p += |feat_data-infected_data|, both using the current vec_addr.
  - Absolute difference is unsigned, DATA_WIDTH bits, zero-extended to ACC_WIDTH. No overflow is possible by parameter rule.
  - If vec_addr==VEC_LEN-1, go to DECIDE and hold vec_addr; otherwise increment vec_addr.
- DECIDE (edge E_VEC_LEN+1, default E65):
  - dist_healthy<=acc_h, dist_infected<=acc_p.
  - is_infected<=(acc_p<acc_h); tie<=(acc_p==acc_h). A tie resolves to healthy.
  - done<=1, busy<=0, vec_addr<=0, go to IDLE.
- done is high for exactly one cycle, E65..E66, and is cleared on the next edge.
- Latency: start sampled at E0, result visible after E65, which is VEC_LEN+1 edges.
- start while busy (ACCUM or DECIDE) is ignored and not queued.
- Back-to-back: start=1 while done=1 (state IDLE) is accepted at that edge. The next result appears VEC_LEN+1 edges later.
- Result outputs change only on DECIDE or reset.

Decomposition:
- Shared package:
  - state enum {IDLE, ACCUM, DECIDE};
  - default width constants (DATA_WIDTH, ADDR_BITS, VEC_LEN);
  - a function computing the minimum ACC_WIDTH, used in an elaboration-time check.
- Sub-module l1_dist_acc:
  - one abs-diff plus accumulator with clear and enable;
  - instantiated twice, once for healthy and once for infected.
- FSM, address counter and decision compare live in the top level.

Test Plan:
- Feature all 0, healthy all 0, infected all 15, start at E0 -> done only in cycle after E65; dist_healthy=0, dist_infected=960, is_infected=0, tie=0; vec_addr steps 0..63 on E0..E63 and is held during DECIDE.
- Feature all 15, healthy all 0, infected all 15 -> dist_healthy=960, dist_infected=0, is_infected=1.
- Feature all 4, healthy all 3, infected all 5 -> dist_healthy=64, dist_infected=64, tie=1, is_infected=0.
- start pulses at E0 and again at E10 (busy) -> exactly one done after E65; results as for a single run; no second done within 200 cycles.
- rst asserted asynchronously mid-cycle between E30 and E31 -> all outputs 0 immediately, no done. A fresh start afterwards with mixed data yields correct distances. Example: feature[i]=i%16, healthy=0, infected=15 -> dist_healthy=480, dist_infected=480, tie=1.
- start held high continuously -> runs accepted at E0 and E66; done strobes after E65 and E131; busy low only for the DECIDE-to-restart edge.
